// File: rtl/cpu_pkg.sv
// Shared constants for the CPU subsystem: data width, default frame sync byte
// and the program loader state encoding.
package cpu_pkg;

    localparam int DATA_W = 8;
    localparam logic [DATA_W-1:0] SYNC_DEFAULT = 8'hA5;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LEN  = 3'd1;
    localparam logic [2:0] ST_DATA = 3'd2;
    localparam logic [2:0] ST_SUM  = 3'd3;
    localparam logic [2:0] ST_ERR  = 3'd4;

endpackage

// File: rtl/prog_loader.sv
// Framed byte-stream program loader: halts the CPU, writes the payload into RAM,
// verifies a zero-sum checksum and pulses run on a good frame.
module prog_loader
    import cpu_pkg::*;
#(
    parameter logic [DATA_W-1:0] SYNC = SYNC_DEFAULT,
    parameter logic [DATA_W-1:0] BASE = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [DATA_W-1:0] ld_addr,
    output logic [DATA_W-1:0] ld_data,
    output logic              ld_wren,
    output logic              cpu_halt,
    output logic              cpu_run,
    output logic              busy,
    output logic              err
);

    logic [2:0]        state_q, state_d;
    logic              ready_q, ready_d;
    logic [8:0]        rem_q, rem_d;
    logic [DATA_W-1:0] ptr_q, ptr_d;
    logic [DATA_W-1:0] sum_q, sum_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              wren_q, wren_d;
    logic              halt_q, halt_d;
    logic              run_q, run_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;

    logic              accept;
    logic [DATA_W-1:0] total;

    assign accept = in_valid && ready_q;
    assign total  = sum_q + in_data;

    always_comb begin
        state_d = state_q;
        ready_d = 1'b1;
        rem_d   = rem_q;
        ptr_d   = ptr_q;
        sum_d   = sum_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wren_d  = 1'b0;
        halt_d  = halt_q;
        run_d   = 1'b0;
        busy_d  = busy_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE, ST_ERR: begin
                if (accept && in_data == SYNC) begin
                    state_d = ST_LEN;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                    halt_d  = 1'b1;
                end
            end
            ST_LEN: begin
                if (accept) begin
                    // A length byte of zero encodes a full 256-byte payload
                    rem_d   = (in_data == '0) ? 9'd256 : {1'b0, in_data};
                    sum_d   = in_data;
                    ptr_d   = BASE;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (accept) begin
                    wren_d = 1'b1;
                    addr_d = ptr_q;
                    data_d = in_data;
                    ptr_d  = ptr_q + 8'd1;
                    sum_d  = total;
                    rem_d  = rem_q - 9'd1;
                    if (rem_q == 9'd1) begin
                        state_d = ST_SUM;
                    end
                end
            end
            ST_SUM: begin
                if (accept) begin
                    busy_d = 1'b0;
                    if (total == '0) begin
                        state_d = ST_IDLE;
                        run_d   = 1'b1;
                        halt_d  = 1'b0;
                    end else begin
                        // Bad frame keeps the core halted until a good one arrives
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b0;
            rem_q   <= '0;
            ptr_q   <= '0;
            sum_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            wren_q  <= 1'b0;
            halt_q  <= 1'b0;
            run_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            rem_q   <= rem_d;
            ptr_q   <= ptr_d;
            sum_q   <= sum_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wren_q  <= wren_d;
            halt_q  <= halt_d;
            run_q   <= run_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign in_ready = ready_q;
    assign ld_addr  = addr_q;
    assign ld_data  = data_q;
    assign ld_wren  = wren_q;
    assign cpu_halt = halt_q;
    assign cpu_run  = run_q;
    assign busy     = busy_q;
    assign err      = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: per-cycle vector table plus hand sequences
// for mid-frame reset and a 256-byte wrapping frame.
module tb_prog_loader;
    import cpu_pkg::*;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;

    logic       ready0, wren0, halt0, run0, busy0, err0;
    logic [7:0] addr0, data0;
    logic       ready1, wren1, halt1, run1, busy1, err1;
    logic [7:0] addr1, data1;

    int errors = 0;
    int checks = 0;

    prog_loader #(.SYNC(8'hA5), .BASE(8'h00)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(ready0), .ld_addr(addr0), .ld_data(data0), .ld_wren(wren0),
        .cpu_halt(halt0), .cpu_run(run0), .busy(busy0), .err(err0)
    );

    prog_loader #(.SYNC(8'hA5), .BASE(8'hFE)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(ready1), .ld_addr(addr1), .ld_data(data1), .ld_wren(wren1),
        .cpu_halt(halt1), .cpu_run(run1), .busy(busy1), .err(err1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       wr;
        logic [7:0] ad;
        logic [7:0] dt;
        logic       run;
        logic       halt;
        logic       busy;
        logic       err;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic v, input logic [7:0] d, input logic wr,
                                input logic [7:0] ad, input logic [7:0] dt,
                                input logic run, input logic halt,
                                input logic busy, input logic err);
        vec_t r;
        r.v = v; r.d = d; r.wr = wr; r.ad = ad; r.dt = dt;
        r.run = run; r.halt = halt; r.busy = busy; r.err = err;
        vecs.push_back(r);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic [7:0] d);
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic run_row(input vec_t r, input string tag);
        step(r.v, r.d);
        $display("%s: v=%0b d=%02h wren=%0b addr=%02h data=%02h run=%0b halt=%0b busy=%0b err=%0b",
                 tag, r.v, r.d, wren0, addr0, data0, run0, halt0, busy0, err0);
        chk({tag, " in_ready"}, 32'(ready0), 32'd1);
        chk({tag, " ld_wren"}, 32'(wren0), 32'(r.wr));
        if (r.wr) begin
            chk({tag, " ld_addr"}, 32'(addr0), 32'(r.ad));
            chk({tag, " ld_data"}, 32'(data0), 32'(r.dt));
        end
        chk({tag, " cpu_run"}, 32'(run0), 32'(r.run));
        chk({tag, " cpu_halt"}, 32'(halt0), 32'(r.halt));
        chk({tag, " busy"}, 32'(busy0), 32'(r.busy));
        chk({tag, " err"}, 32'(err0), 32'(r.err));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " in_ready"}, 32'(ready0), 32'd0);
        chk({tag, " ld_addr"}, 32'(addr0), 32'd0);
        chk({tag, " ld_data"}, 32'(data0), 32'd0);
        chk({tag, " ld_wren"}, 32'(wren0), 32'd0);
        chk({tag, " cpu_halt"}, 32'(halt0), 32'd0);
        chk({tag, " cpu_run"}, 32'(run0), 32'd0);
        chk({tag, " busy"}, 32'(busy0), 32'd0);
        chk({tag, " err"}, 32'(err0), 32'd0);
    endtask

    initial begin
        vec_t r;
        logic [7:0] exp_addr;

        // Good frame: sum 03+11+22+33 = 69, CHK 97
        add(1, 8'hA5, 0, 8'h00, 8'h00, 0, 1, 1, 0);
        add(1, 8'h03, 0, 8'h00, 8'h00, 0, 1, 1, 0);
        add(1, 8'h11, 1, 8'h00, 8'h11, 0, 1, 1, 0);
        add(1, 8'h22, 1, 8'h01, 8'h22, 0, 1, 1, 0);
        add(1, 8'h33, 1, 8'h02, 8'h33, 0, 1, 1, 0);
        add(1, 8'h97, 0, 8'h00, 8'h00, 1, 0, 0, 0);
        add(0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0, 0);
        // Bad checksum, then a non-sync byte in ERR is dropped
        add(1, 8'hA5, 0, 8'h00, 8'h00, 0, 1, 1, 0);
        add(1, 8'h01, 0, 8'h00, 8'h00, 0, 1, 1, 0);
        add(1, 8'h55, 1, 8'h00, 8'h55, 0, 1, 1, 0);
        add(1, 8'h00, 0, 8'h00, 8'h00, 0, 1, 0, 1);
        add(0, 8'h00, 0, 8'h00, 8'h00, 0, 1, 0, 1);
        add(1, 8'h33, 0, 8'h00, 8'h00, 0, 1, 0, 1);
        // Recovery frame: 01+7F = 80, CHK 80
        add(1, 8'hA5, 0, 8'h00, 8'h00, 0, 1, 1, 0);
        add(1, 8'h01, 0, 8'h00, 8'h00, 0, 1, 1, 0);
        add(1, 8'h7F, 1, 8'h00, 8'h7F, 0, 1, 1, 0);
        add(1, 8'h80, 0, 8'h00, 8'h00, 1, 0, 0, 0);
        add(0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0, 0);
        // Garbage before sync; in-frame A5 is payload
        add(1, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0, 0);
        add(1, 8'hFF, 0, 8'h00, 8'h00, 0, 0, 0, 0);
        add(1, 8'hA5, 0, 8'h00, 8'h00, 0, 1, 1, 0);
        add(1, 8'h01, 0, 8'h00, 8'h00, 0, 1, 1, 0);
        add(1, 8'hA5, 1, 8'h00, 8'hA5, 0, 1, 1, 0);
        add(1, 8'h5A, 0, 8'h00, 8'h00, 1, 0, 0, 0);
        add(0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0, 0);
        // Stall for 5 cycles after second payload byte; sum 04+10+20+30+40 = A4, CHK 5C
        add(1, 8'hA5, 0, 8'h00, 8'h00, 0, 1, 1, 0);
        add(1, 8'h04, 0, 8'h00, 8'h00, 0, 1, 1, 0);
        add(1, 8'h10, 1, 8'h00, 8'h10, 0, 1, 1, 0);
        add(1, 8'h20, 1, 8'h01, 8'h20, 0, 1, 1, 0);
        for (int i = 0; i < 5; i++) add(0, 8'hA5, 0, 8'h00, 8'h00, 0, 1, 1, 0);
        add(1, 8'h30, 1, 8'h02, 8'h30, 0, 1, 1, 0);
        add(1, 8'h40, 1, 8'h03, 8'h40, 0, 1, 1, 0);
        add(1, 8'h5C, 0, 8'h00, 8'h00, 1, 0, 0, 0);
        add(0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0, 0);

        rst = 1'b0;
        in_valid = 1'b0;
        in_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("por");
        rst = 1'b1;
        #1;
        chk("post-release in_ready", 32'(ready0), 32'd0);
        step(0, 8'h00);
        chk("first-cycle in_ready", 32'(ready0), 32'd1);

        for (int i = 0; i < vecs.size(); i++) begin
            run_row(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset after 2 of 4 payload bytes, while a write is visible
        step(1, 8'hA5);
        step(1, 8'h04);
        step(1, 8'h10);
        step(1, 8'h20);
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        $display("mid-reset: wren=%0b halt=%0b busy=%0b", wren0, halt0, busy0);
        chk_reset_vals("midrst");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst release in_ready", 32'(ready0), 32'd0);
        step(0, 8'h00);
        // Fresh frame at BASE: 02+AA+BB = 67, CHK 99
        r = '{1, 8'hA5, 0, 8'h00, 8'h00, 0, 1, 1, 0}; run_row(r, "fresh0");
        r = '{1, 8'h02, 0, 8'h00, 8'h00, 0, 1, 1, 0}; run_row(r, "fresh1");
        r = '{1, 8'hAA, 1, 8'h00, 8'hAA, 0, 1, 1, 0}; run_row(r, "fresh2");
        r = '{1, 8'hBB, 1, 8'h01, 8'hBB, 0, 1, 1, 0}; run_row(r, "fresh3");
        r = '{1, 8'h99, 0, 8'h00, 8'h00, 1, 0, 0, 0}; run_row(r, "fresh4");

        // 256-byte frame on the BASE=FE instance; payload i, sum = 80, CHK 80
        step(1, 8'hA5);
        step(1, 8'h00);
        exp_addr = 8'hFE;
        for (int i = 0; i < 256; i++) begin
            step(1, 8'(i));
            if (i < 3 || i > 252)
                $display("wrap%0d: wren=%0b addr=%02h data=%02h", i, wren1, addr1, data1);
            chk($sformatf("wrap%0d ld_wren", i), 32'(wren1), 32'd1);
            chk($sformatf("wrap%0d ld_addr", i), 32'(addr1), 32'(exp_addr));
            chk($sformatf("wrap%0d ld_data", i), 32'(data1), i);
            exp_addr = exp_addr + 8'd1;
        end
        chk("wrap busy before chk", 32'(busy1), 32'd1);
        chk("wrap run before chk", 32'(run1), 32'd0);
        step(1, 8'h80);
        $display("wrap chk: run=%0b halt=%0b err=%0b wren=%0b", run1, halt1, err1, wren1);
        chk("wrap cpu_run", 32'(run1), 32'd1);
        chk("wrap cpu_halt", 32'(halt1), 32'd0);
        chk("wrap err", 32'(err1), 32'd0);
        chk("wrap ld_wren after chk", 32'(wren1), 32'd0);
        step(0, 8'h00);
        chk("wrap run one cycle", 32'(run1), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
# prog_loader

Host-side program loader that sits upstream of the CPU core and its RAM. It accepts a framed byte stream over a valid/ready handshake and writes the payload into RAM through the core's RAM write port. It holds the CPU halted while loading, verifies a checksum, and pulses `run` to start execution only when the frame is good.

## Interface
- `SYNC`, default 8'hA5: frame start byte.
- `BASE`, default 8'h00: RAM address of the first payload byte.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `in_valid` input 1: host byte valid.
- `in_data` input 8: host byte.
- `in_ready` output 1: loader accepts a byte this cycle.
- `ld_addr` output 8: RAM write address (registered).
- `ld_data` output 8: RAM write data (registered).
- `ld_wren` output 1: RAM write enable, one cycle per payload byte.
- `cpu_halt` output 1: drives the core `halt` input.
- `cpu_run` output 1: one-cycle pulse to the core `run` input.
- `busy` output 1: frame in progress.
- `err` output 1: sticky checksum error.

## Operation
- A byte is accepted on a rising edge where `in_valid && in_ready`.
- Frame format: `SYNC`, then `LEN`, then `LEN` payload bytes, then `CHK`. `LEN` = 0 means 256 bytes.
- Checksum rule: the 8-bit modulo-256 sum of `LEN`, all payload bytes and `CHK` must equal 8'h00.
- FSM states: IDLE, LEN, DATA, SUM, ERR.
- IDLE: accept every byte. Bytes other than `SYNC` are dropped. On `SYNC`: go to LEN, clear `err`, raise `busy` and `cpu_halt`.
- LEN: store the length in a 9-bit remaining counter (0 → 256). Seed the sum with `LEN`. Set the write pointer to `BASE`. Go to DATA.
- DATA: for each byte, on the next cycle `ld_wren`=1 with `ld_addr`=pointer and `ld_data`=byte. The pointer increments mod 256 and wraps 8'hFF → 8'h00. Sum += byte, remaining −= 1. When remaining reaches 0, go to SUM.
- SUM: add `CHK`.
  - Total 0: go to IDLE. `cpu_run` pulses on the next cycle. `cpu_halt` and `busy` drop that same cycle.
  - Total nonzero: go to ERR. Set `err`, drop `busy`, keep `cpu_halt`=1, no `cpu_run`.
- ERR: behaves like IDLE (drops non-`SYNC` bytes). A `SYNC` byte restarts the frame and clears `err`.
- A `SYNC` value inside LEN, DATA or SUM is ordinary data.

## Timing
- Reset values: `in_ready`=0, `ld_addr`=8'h00, `ld_data`=8'h00, `ld_wren`=0, `cpu_halt`=0, `cpu_run`=0, `busy`=0, `err`=0. State is IDLE.
- `in_ready` is 0 only in the first cycle after reset deassertion, and 1 in every state thereafter. Throughput is one byte per cycle.
- Write latency is exactly one cycle from payload acceptance to `ld_wren`. Back-to-back payload bytes give back-to-back writes.
- `cpu_halt` rises on the edge that accepts `SYNC`.
- `cpu_run` is high for exactly one cycle, the cycle after `CHK` is accepted. `cpu_halt` is low in that same cycle.
- `in_valid` low mid-frame simply stalls the frame. There is no timeout.
- Reset mid-frame: all outputs return to reset values immediately. A pending write is dropped. RAM contents are not restored.

## Structure
- Shared package `cpu_pkg` holds the state encoding localparams (IDLE..ERR), the default `SYNC`, and the 8-bit data width constant.
- Single module. The FSM, counter, pointer and sum are all inline; no sub-module is warranted.
- The top level muxes `ld_addr`, `ld_data` and `ld_wren` onto the RAM port while `cpu_halt`=1. That mux is outside this block.

## Test plan
- Good frame: A5, 03, 11, 22, 33, CHK=8'h97 (03+11+22+33 = 69). Expect writes 00←11, 01←22, 02←33 on consecutive cycles, then one `cpu_run` pulse; `err`=0.
- Bad checksum: A5, 01, 55, 00. Expect write 00←55, no `cpu_run`, `err`=1, `cpu_halt` stays 1. A following good frame clears `err` and pulses `cpu_run`.
- Garbage before sync: 00, FF, A5, 01, A5, 5A. Only one write (00←A5, the in-frame A5 is data). `cpu_run` pulses because 01+A5+5A = 00.
- Wrap and 256: `BASE`=8'hFE, LEN=00. Expect 256 writes, addresses FE, FF, 00, …, FD; `cpu_run` on the correct checksum.
- Stall: drop `in_valid` for 5 cycles after the second payload byte. Expect no spurious `ld_wren` and `busy`=1 throughout.
- Reset mid-DATA: assert `rst` low after 2 of 4 payload bytes. All outputs go to reset values immediately. After release, the next A5 starts a fresh frame at `BASE`.
